// File: rtl/puf_ctrl_pkg.sv
// Shared types and widths for the arbiter-PUF challenge driver.
package puf_ctrl_pkg;

  // Controller phases: idle, challenge load, race edge high, race edge low, result hold.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RACE_HI = 3'd2,
    RACE_LO = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Per-bit vote counter width; NUM_EVALS <= 15 keeps it from saturating.
  localparam int VOTE_W = 4;

  // Phase counter width; covers SETTLE up to 255.
  localparam int SETTLE_W = 8;

  // Evaluation counter width; covers NUM_EVALS up to 15.
  localparam int EVAL_W = 4;

endpackage

// File: rtl/puf_vote_accum.sv
// Bank of per-bit vote counters with combinational majority and agreement outputs.
module puf_vote_accum
  import puf_ctrl_pkg::*;
#(
  parameter int RESP_W    = 64,
  parameter int NUM_EVALS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [RESP_W-1:0] i_bits,
  output logic [RESP_W-1:0] o_majority,
  output logic [RESP_W-1:0] o_stable
);

  localparam logic [VOTE_W-1:0] HALF = VOTE_W'(NUM_EVALS / 2);
  localparam logic [VOTE_W-1:0] FULL = VOTE_W'(NUM_EVALS);

  logic [VOTE_W-1:0] r_cnt [RESP_W];

  // Count how many evaluations returned a 1 for each response bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RESP_W; i++) begin
      if (rst || i_clr) begin
        r_cnt[i] <= {VOTE_W{1'b0}};
      end else if (i_acc) begin
        r_cnt[i] <= r_cnt[i] + {{(VOTE_W-1){1'b0}}, i_bits[i]};
      end else begin
        r_cnt[i] <= r_cnt[i];
      end
    end
  end

  // A bit is 1 when more than half the evaluations saw 1; stable when all agreed.
  always_comb begin
    o_majority = {RESP_W{1'b0}};
    o_stable   = {RESP_W{1'b0}};
    for (int i = 0; i < RESP_W; i++) begin
      o_majority[i] = (r_cnt[i] > HALF);
      o_stable[i]   = (r_cnt[i] == {VOTE_W{1'b0}}) || (r_cnt[i] == FULL);
    end
  end

endmodule

// File: rtl/puf_challenge_driver.sv
// Arbiter-PUF initiator: applies a challenge, races the arbiters NUM_EVALS
// times, majority-votes the synchronized responses and returns the result.
module puf_challenge_driver
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W    = 64,
  parameter int RESP_W    = 64,
  parameter int SETTLE    = 4,
  parameter int NUM_EVALS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_stable,
  output logic              busy,
  output logic              puf_a,
  output logic              puf_b,
  output logic [CHAL_W-1:0] puf_c,
  input  logic [RESP_W-1:0] puf_response
);

  localparam logic [SETTLE_W-1:0] PHASE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [EVAL_W-1:0]   EVAL_LAST  = EVAL_W'(NUM_EVALS - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SETTLE_W-1:0] r_phase;
  logic [SETTLE_W-1:0] w_phase_nxt;
  logic [EVAL_W-1:0]   r_eval;
  logic [EVAL_W-1:0]   w_eval_nxt;
  logic                w_accept;
  logic                w_clr;
  logic                w_acc;
  logic                w_phase_last;

  logic [RESP_W-1:0]   r_sync1;
  logic [RESP_W-1:0]   r_sync2;
  logic [RESP_W-1:0]   w_majority;
  logic [RESP_W-1:0]   w_stable;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [RESP_W-1:0]   r_resp_data;
  logic [RESP_W-1:0]   r_resp_stable;
  logic                r_busy;
  logic                r_puf_a;
  logic                r_puf_b;
  logic [CHAL_W-1:0]   r_puf_c;

  assign w_phase_last = (r_phase == PHASE_LAST);

  // Two-flop synchronizer for the arbiter outputs, which are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {RESP_W{1'b0}};
      r_sync2 <= {RESP_W{1'b0}};
    end else begin
      r_sync1 <= puf_response;
      r_sync2 <= r_sync1;
    end
  end

  // State, phase and evaluation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= {SETTLE_W{1'b0}};
      r_eval  <= {EVAL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_eval  <= w_eval_nxt;
    end
  end

  // Next-state logic: each phase lasts SETTLE cycles; votes are taken on the last race-high cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_eval_nxt  = r_eval;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_clr       = 1'b1;
          w_eval_nxt  = {EVAL_W{1'b0}};
          w_phase_nxt = {SETTLE_W{1'b0}};
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (w_phase_last) begin
          w_phase_nxt = {SETTLE_W{1'b0}};
          w_state_nxt = RACE_HI;
        end else begin
          w_phase_nxt = r_phase + {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
      end
      RACE_HI: begin
        if (w_phase_last) begin
          w_acc       = 1'b1;
          w_phase_nxt = {SETTLE_W{1'b0}};
          w_state_nxt = RACE_LO;
        end else begin
          w_phase_nxt = r_phase + {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
      end
      RACE_LO: begin
        if (w_phase_last) begin
          w_phase_nxt = {SETTLE_W{1'b0}};
          if (r_eval == EVAL_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_eval_nxt  = r_eval + {{(EVAL_W-1){1'b0}}, 1'b1};
            w_state_nxt = RACE_HI;
          end
        end else begin
          w_phase_nxt = r_phase + {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (resp_ready && r_resp_valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= {RESP_W{1'b0}};
      r_resp_stable <= {RESP_W{1'b0}};
      r_busy        <= 1'b0;
      r_puf_a       <= 1'b0;
      r_puf_b       <= 1'b0;
      r_puf_c       <= {CHAL_W{1'b0}};
    end else begin
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == DONE);
      r_busy       <= (w_state_nxt != IDLE);
      r_puf_a      <= (w_state_nxt == RACE_HI);
      r_puf_b      <= (w_state_nxt == RACE_HI);
      if (w_accept) begin
        r_puf_c <= req_chal;
      end else begin
        r_puf_c <= r_puf_c;
      end
      if ((w_state_nxt == DONE) && (r_state != DONE)) begin
        r_resp_data   <= w_majority;
        r_resp_stable <= w_stable;
      end else begin
        r_resp_data   <= r_resp_data;
        r_resp_stable <= r_resp_stable;
      end
    end
  end

  puf_vote_accum #(
    .RESP_W    (RESP_W),
    .NUM_EVALS (NUM_EVALS)
  ) u_vote (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_acc      (w_acc),
    .i_bits     (r_sync2),
    .o_majority (w_majority),
    .o_stable   (w_stable)
  );

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_stable = r_resp_stable;
  assign busy        = r_busy;
  assign puf_a       = r_puf_a;
  assign puf_b       = r_puf_b;
  assign puf_c       = r_puf_c;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Bench for puf_challenge_driver: unit 0 uses the defaults (SETTLE=4, NUM_EVALS=3),
// unit 1 uses SETTLE=3, NUM_EVALS=1. A behavioural PUF returns tbl[k] during race k.
module tb_puf_challenge_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          u;
  logic        rv;
  logic [63:0] rc;
  logic        rd;

  logic        rr0, vv0, bz0, pa0, pb0;
  logic [63:0] d0, s0, pc0, pr0;
  logic        rr1, vv1, bz1, pa1, pb1;
  logic [63:0] d1, s1, pc1, pr1;

  logic [63:0] tbl [15];
  int          base;
  int          pt0 = 0;
  int          pt1 = 0;
  int          idx0, idx1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] chal;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] exp_d;
    logic [63:0] exp_s;
  } vec_t;
  vec_t vecs [4];

  // Race counters: each rising race edge moves the PUF model to its next evaluation.
  always @(posedge pa0) pt0 <= pt0 + 1;
  always @(posedge pa1) pt1 <= pt1 + 1;

  assign idx0 = pt0 - base - 1;
  assign idx1 = pt1 - base - 1;
  assign pr0  = (idx0 >= 0 && idx0 < 15) ? tbl[idx0] : 64'h0;
  assign pr1  = (idx1 >= 0 && idx1 < 15) ? tbl[idx1] : 64'h0;

  wire m_rr = (u == 0) ? rr0 : rr1;
  wire m_vv = (u == 0) ? vv0 : vv1;
  wire m_bz = (u == 0) ? bz0 : bz1;
  wire m_pa = (u == 0) ? pa0 : pa1;
  wire m_pb = (u == 0) ? pb0 : pb1;
  wire [63:0] m_d  = (u == 0) ? d0 : d1;
  wire [63:0] m_s  = (u == 0) ? s0 : s1;
  wire [63:0] m_pc = (u == 0) ? pc0 : pc1;
  wire rv0 = (u == 0) && rv;
  wire rv1 = (u == 1) && rv;
  wire rd0 = (u == 0) && rd;
  wire rd1 = (u == 1) && rd;

  puf_challenge_driver #(.CHAL_W(64), .RESP_W(64), .SETTLE(4), .NUM_EVALS(3)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_chal(rc),
    .resp_valid(vv0), .resp_ready(rd0), .resp_data(d0), .resp_stable(s0),
    .busy(bz0), .puf_a(pa0), .puf_b(pb0), .puf_c(pc0), .puf_response(pr0)
  );

  puf_challenge_driver #(.CHAL_W(64), .RESP_W(64), .SETTLE(3), .NUM_EVALS(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_chal(rc),
    .resp_valid(vv1), .resp_ready(rd1), .resp_data(d1), .resp_stable(s1),
    .busy(bz1), .puf_a(pa1), .puf_b(pb1), .puf_c(pc1), .puf_response(pr1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: count ones per bit over the first n evaluations, then vote.
  task automatic model(input int n, output logic [63:0] ed, output logic [63:0] es);
    int cnt;
    for (int b = 0; b < 64; b++) begin
      cnt = 0;
      for (int e = 0; e < n; e++) cnt += int'(tbl[e][b]);
      ed[b] = (cnt * 2 > n);
      es[b] = (cnt == 0) || (cnt == n);
    end
  endtask

  // One full transaction on the selected unit with timing, waveform and result checks.
  task automatic run_txn(input string tag, input logic [63:0] chal, input logic [63:0] ed,
                         input logic [63:0] es, input int hold, input bit spam, input bit b2b);
    int s, n, lat, m, pulses, run, badw, abd, pcb, waited, hb;
    logic prev;
    s = (u == 0) ? 4 : 3;
    n = (u == 0) ? 3 : 1;
    lat = 1 + s * (1 + 2 * n);
    waited = 0;
    while (m_rr !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, " req_ready"}, {63'h0, m_rr}, 64'h1);
    if (b2b) chk({tag, " b2b_wait"}, 64'(waited), 64'h0);
    rv = 1'b1;
    rc = chal;
    base = (u == 0) ? pt0 : pt1;
    tick();
    if (spam) rc = {$urandom, $urandom};
    else rv = 1'b0;
    chk({tag, " puf_c"}, m_pc, chal);
    chk({tag, " busy"}, {63'h0, m_bz}, 64'h1);
    m = 1; pulses = 0; run = 0; badw = 0; abd = 0; pcb = 0; prev = 1'b0;
    while (m_vv !== 1'b1 && m < 400) begin
      if (m_pa !== m_pb) abd++;
      if (m_pc !== chal) pcb++;
      if (spam && m_rr !== 1'b0) pcb++;
      if (m_pa === 1'b1) begin
        if (!prev) pulses++;
        run++;
      end else begin
        if (prev && run != s) badw++;
        run = 0;
      end
      prev = m_pa;
      if (spam) rc = {$urandom, $urandom};
      tick();
      m++;
    end
    rv = 1'b0;
    chk({tag, " latency"}, 64'(m), 64'(lat));
    chk({tag, " pulses"}, 64'(pulses), 64'(n));
    chk({tag, " pulse_width_errs"}, 64'(badw), 64'h0);
    chk({tag, " a_ne_b"}, 64'(abd), 64'h0);
    chk({tag, " chal_hold_errs"}, 64'(pcb), 64'h0);
    chk({tag, " resp_data"}, m_d, ed);
    chk({tag, " resp_stable"}, m_s, es);
    hb = 0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (m_vv !== 1'b1 || m_d !== ed || m_s !== es || m_rr !== 1'b0 || m_pc !== chal) hb++;
    end
    if (hold > 0) chk({tag, " hold_errs"}, 64'(hb), 64'h0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk({tag, " post_valid"}, {63'h0, m_vv}, 64'h0);
    chk({tag, " post_ready"}, {63'h0, m_rr}, 64'h1);
    chk({tag, " post_busy"}, {63'h0, m_bz}, 64'h0);
    chk({tag, " post_puf_c"}, m_pc, chal);
  endtask

  initial begin
    logic [63:0] ed, es, ch;
    int w, seen;
    logic prev;

    vecs[0] = '{64'h1111_2222_3333_4444, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567,
                64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{64'h0000_0000_0000_00A5, 64'h1, 64'h2, 64'h1,
                64'h1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[2] = '{64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0,
                64'hF000_F000_F000_F000, 64'h000F_000F_000F_000F};

    for (int i = 0; i < 15; i++) tbl[i] = 64'h0;
    u = 0; rv = 1'b0; rc = 64'h0; rd = 1'b0; base = 0;
    rst = 1'b1;
    tick(); tick(); tick();

    // Reset values on both units.
    for (int k = 0; k < 2; k++) begin
      u = k;
      #0;
      chk("rst req_ready", {63'h0, m_rr}, 64'h0);
      chk("rst resp_valid", {63'h0, m_vv}, 64'h0);
      chk("rst busy", {63'h0, m_bz}, 64'h0);
      chk("rst puf_ab", {62'h0, m_pa, m_pb}, 64'h0);
      chk("rst puf_c", m_pc, 64'h0);
      chk("rst resp_data", m_d, 64'h0);
      chk("rst resp_stable", m_s, 64'h0);
    end
    u = 0;
    rst = 1'b0;
    tick();
    chk("first req_ready", {63'h0, m_rr}, 64'h1);

    // Table-driven vectors on the default unit; vector 0 also holds resp_ready low 10 cycles.
    for (int i = 0; i < 4; i++) begin
      tbl[0] = vecs[i].e0; tbl[1] = vecs[i].e1; tbl[2] = vecs[i].e2;
      run_txn($sformatf("vec%0d", i), vecs[i].chal, vecs[i].exp_d, vecs[i].exp_s,
              (i == 0) ? 10 : 0, 1'b0, 1'b0);
    end

    // Requests held valid with a changing challenge while busy.
    tbl[0] = 64'hA5A5_0000_1234_FFFF; tbl[1] = 64'h5A5A_0000_1234_FFFF; tbl[2] = 64'hA5A5_0000_1234_0000;
    model(3, ed, es);
    run_txn("spam", 64'hCAFE_F00D_0BAD_BEEF, ed, es, 3, 1'b1, 1'b0);

    // Reset asserted during the second race-high phase.
    w = 0;
    while (m_rr !== 1'b1 && w < 20) begin tick(); w++; end
    rv = 1'b1; rc = 64'h7777_8888_9999_AAAA; base = pt0;
    tick();
    rv = 1'b0;
    seen = 0; prev = 1'b0; w = 0;
    while (!(seen == 2 && m_pa === 1'b1) && w < 100) begin
      tick(); w++;
      if (m_pa === 1'b1 && !prev) seen++;
      prev = m_pa;
    end
    chk("midrst reached_race2", 64'(seen), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst puf_ab", {62'h0, m_pa, m_pb}, 64'h0);
    chk("midrst busy", {63'h0, m_bz}, 64'h0);
    chk("midrst resp_valid", {63'h0, m_vv}, 64'h0);
    tick();
    chk("midrst ready", {63'h0, m_rr}, 64'h1);
    tbl[0] = 64'h0F0F_1234_5678_9ABC; tbl[1] = 64'h0F0F_1234_0000_9ABC; tbl[2] = 64'hFFFF_1234_5678_0000;
    model(3, ed, es);
    run_txn("after_rst", 64'h1357_9BDF_2468_ACE0, ed, es, 0, 1'b0, 1'b0);

    // Randomized transactions on the default unit against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < 3; e++) tbl[e] = {$urandom, $urandom};
      ch = {$urandom, $urandom};
      model(3, ed, es);
      run_txn($sformatf("rnd%0d", r), ch, ed, es, int'($urandom_range(0, 3)), 1'b0, r > 0);
    end

    // SETTLE=3, NUM_EVALS=1 unit: back-to-back transactions.
    u = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      tbl[0] = (r == 0) ? 64'hDEADBEEF_01234567 : {$urandom, $urandom};
      ch = {$urandom, $urandom};
      model(1, ed, es);
      run_txn($sformatf("n1_%0d", r), ch, ed, es, 0, 1'b0, r > 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
